// File: rtl/text_render_ctrl.sv
// Text-mode character pipeline: pixel coordinate -> text RAM -> font decoder/ROM -> coloured pixel,
// with a frame-counted blinking cursor overlay. Four stages, all advancing on pix_en.
module text_render_ctrl #(
  parameter int COLS         = 80,
  parameter int ROWS         = 30,
  parameter int CHARA_HEIGHT = 11,
  parameter int TXT_AW       = 12,
  parameter int BLINK_FRAMES = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_en,
  input  logic              vid_active,
  input  logic [9:0]        vid_x,
  input  logic [9:0]        vid_y,
  input  logic              frame_start,
  output logic [TXT_AW-1:0] txt_addr,
  input  logic [7:0]        txt_data,
  output logic [7:0]        dec_ascii,
  output logic [3:0]        dec_line,
  input  logic [7:0]        font_row,
  input  logic              cursor_en,
  input  logic [6:0]        cursor_col,
  input  logic [4:0]        cursor_row,
  input  logic [11:0]       fg_rgb,
  input  logic [11:0]       bg_rgb,
  output logic [11:0]       pix_rgb,
  output logic              pix_active
);

  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // Stage 1 combinational cell decode
  logic [6:0]        col;
  logic [5:0]        row;
  logic              inrange_s;
  logic              cur_s;
  logic [TXT_AW-1:0] addr_s;

  assign col       = vid_x[9:3];
  assign row       = vid_y[9:4];
  assign inrange_s = (int'(col) < COLS) && (int'(row) < ROWS);
  // Cursor is gated by inrange so an off-screen cursor position never paints the border.
  assign cur_s     = cursor_en && inrange_s && (col == cursor_col) && (row == {1'b0, cursor_row});
  assign addr_s    = inrange_s ? (TXT_AW'(row) * TXT_AW'(COLS) + TXT_AW'(col)) : '0;

  // Pipeline registers
  logic [TXT_AW-1:0] txt_addr_q;
  logic [3:0]        s1_line_q;
  logic [2:0]        s1_bit_q, s2_bit_q, s3_bit_q;
  logic              s1_valid_q, s2_valid_q, s3_valid_q;
  logic              s1_active_q, s2_active_q, s3_active_q;
  logic              s1_inrange_q, s2_inrange_q, s3_inrange_q;
  logic              s1_cur_q, s2_cur_q, s3_cur_q;
  logic [7:0]        dec_ascii_q;
  logic [3:0]        dec_line_q, s3_line_q;
  logic [7:0]        font_q;
  logic [11:0]       pix_rgb_q;
  logic              pix_active_q;

  logic [BW-1:0]     blink_cnt_q;
  logic              blink_q;

  logic              glyph_on;
  logic              pix_lit;

  assign glyph_on = font_q[3'd7 - s3_bit_q] && (int'(s3_line_q) < CHARA_HEIGHT) && s3_inrange_q;
  assign pix_lit  = glyph_on ^ (s3_cur_q && blink_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txt_addr_q   <= '0;
      s1_line_q    <= '0;
      s1_bit_q     <= '0;
      s1_valid_q   <= 1'b0;
      s1_active_q  <= 1'b0;
      s1_inrange_q <= 1'b0;
      s1_cur_q     <= 1'b0;
      dec_ascii_q  <= '0;
      dec_line_q   <= '0;
      s2_bit_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_active_q  <= 1'b0;
      s2_inrange_q <= 1'b0;
      s2_cur_q     <= 1'b0;
      font_q       <= '0;
      s3_line_q    <= '0;
      s3_bit_q     <= '0;
      s3_valid_q   <= 1'b0;
      s3_active_q  <= 1'b0;
      s3_inrange_q <= 1'b0;
      s3_cur_q     <= 1'b0;
      pix_rgb_q    <= '0;
      pix_active_q <= 1'b0;
    end else if (pix_en) begin
      txt_addr_q   <= addr_s;
      s1_line_q    <= vid_y[3:0];
      s1_bit_q     <= vid_x[2:0];
      s1_valid_q   <= 1'b1;
      s1_active_q  <= vid_active;
      s1_inrange_q <= inrange_s;
      s1_cur_q     <= cur_s;

      dec_ascii_q  <= txt_data;
      dec_line_q   <= s1_line_q;
      s2_bit_q     <= s1_bit_q;
      s2_valid_q   <= s1_valid_q;
      s2_active_q  <= s1_active_q;
      s2_inrange_q <= s1_inrange_q;
      s2_cur_q     <= s1_cur_q;

      font_q       <= font_row;
      s3_line_q    <= dec_line_q;
      s3_bit_q     <= s2_bit_q;
      s3_valid_q   <= s2_valid_q;
      s3_active_q  <= s2_active_q;
      s3_inrange_q <= s2_inrange_q;
      s3_cur_q     <= s2_cur_q;

      // Bubbles left by reset emit black/inactive until the pipeline has refilled.
      if (s3_valid_q) begin
        pix_active_q <= s3_active_q;
        pix_rgb_q    <= !s3_active_q ? 12'h000 : (pix_lit ? fg_rgb : bg_rgb);
      end else begin
        pix_active_q <= 1'b0;
        pix_rgb_q    <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
    end else if (frame_start) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_q <= '0;
        blink_q     <= ~blink_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BW'(1);
      end
    end
  end

  assign txt_addr   = txt_addr_q;
  assign dec_ascii  = dec_ascii_q;
  assign dec_line   = dec_line_q;
  assign pix_rgb    = pix_rgb_q;
  assign pix_active = pix_active_q;

endmodule
